uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte requesters.
- Grants one requester at a time and latches its byte and parity configuration.
- Issues a single-cycle Data_valid toward the transmitter, then tracks the transmitter's busy flag through the whole frame.
- Returns a per-requester DONE pulse, plus ERR if the transmitter never starts.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width per requester.
- BUSY_TIMEOUT, 16, cycles to wait for TX_BUSY rise after Data_valid before declaring error.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- REQ  in  NUM_REQ  per-requester request; held high until its DONE.
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies [DATA_WIDTH*i +: DATA_WIDTH].
- REQ_PAR_EN  in  NUM_REQ  per-requester parity enable.
- REQ_PAR_TYP  in  NUM_REQ  per-requester parity type (0 even, 1 odd).
- TX_BUSY  in  1  busy flag from the UART transmitter.
- P_DATA  out  DATA_WIDTH  byte to the transmitter.
- Data_valid  out  1  one-cycle launch strobe to the transmitter.
- PAR_EN  out  1  parity enable to the transmitter.
- PAR_TYP  out  1  parity type to the transmitter.
- GNT  out  NUM_REQ  one-hot current owner; all-zero when idle.
- DONE  out  NUM_REQ  one-cycle completion pulse, one-hot.
- ERR  out  1  one-cycle timeout pulse, coincident with DONE.

Behaviour:
- Reset (RST low, async):
  - State IDLE.
  - P_DATA=0, Data_valid=0, PAR_EN=0, PAR_TYP=0, GNT=0, DONE=0, ERR=0.
  - Timeout counter 0; RR pointer so requester 0 has highest priority.
  - Reset mid-frame abandons the frame with no DONE.
- All outputs are registered.
- States: IDLE, START, WAIT_BUSY, SEND, COMPLETE.
- IDLE:
  - If any REQ=1 and TX_BUSY=0, select winner by round robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - On that edge: GNT<=onehot(winner); P_DATA, PAR_EN, PAR_TYP <= winner's REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP; Data_valid<=1; go to START.
  - If TX_BUSY=1, no grant is made.
- START: Data_valid is high for exactly this one cycle. Next edge: Data_valid<=0, counter<=0, go to WAIT_BUSY.
- WAIT_BUSY:
  - TX_BUSY=1 -> SEND.
  - Otherwise counter++; when counter reaches BUSY_TIMEOUT-1 -> COMPLETE with ERR<=1.
- SEND: stay while TX_BUSY=1; TX_BUSY=0 -> COMPLETE.
- COMPLETE:
  - DONE=GNT for one cycle (ERR=1 too if timed out).
  - Next edge: GNT<=0, DONE<=0, ERR<=0, last_grant<=winner, go to IDLE.
- P_DATA, PAR_EN, PAR_TYP stay stable from START through COMPLETE; they hold their last value in IDLE.
- Launch latency: REQ high in IDLE at edge n -> Data_valid high in cycle n+1.
- A requester must drop REQ in the cycle after DONE. If REQ is still high, it is eligible again but ranks lowest behind other pending requesters.
- REQ dropped while granted is ignored; the frame completes and DONE still pulses.
- REQ_DATA changes after grant have no effect.
- Single requester: back-to-back frames with one IDLE cycle between COMPLETE and the next START.
- Gap between frames: minimum 3 cycles (COMPLETE, IDLE, START) from the end of one frame's busy to the next Data_valid.

Decomposition:
- Shared package/header uart_tx_pkg holds:
  - state encodings (IDLE=0, START=1, WAIT_BUSY=2, SEND=3, COMPLETE=4, 3-bit);
  - default DATA_WIDTH;
  - parity type constants (EVEN=0, ODD=1).
- Sub-module rr_arbiter (parameter NUM_REQ):
  - combinational winner from REQ and the last_grant pointer;
  - outputs one-hot grant and a valid flag.
- The FSM, data latching and timeout counter live in uart_tx_arbiter.

Test Plan:
- Single request:
  - Stimulus: REQ=0001, REQ_DATA[7:0]=0xA5, PAR_EN=1, PAR_TYP=0; model busy high 11 cycles starting 1 cycle after Data_valid.
  - Required: one Data_valid pulse with P_DATA=0xA5; GNT=0001 through frame; DONE=0001 once; ERR=0.
- Round-robin fairness: REQ=1111 held permanently -> grant order 0,1,2,3,0,1; each DONE one-hot in matching order.
- Busy blocking: TX_BUSY forced 1 while REQ=0010 -> no GNT and no Data_valid until TX_BUSY=0; then grant follows within 1 cycle.
- Timeout: REQ=0100, TX_BUSY held 0 -> Data_valid once; after 16 cycles in WAIT_BUSY, DONE=0100 with ERR=1; next grant proceeds normally.
- Reset mid-frame: RST low during SEND -> all outputs 0 immediately (async); after release, requester 0 has top priority and no DONE pulse appears for the aborted frame.
- Data stability: change REQ_DATA and drop REQ during SEND -> P_DATA, PAR_EN, PAR_TYP unchanged; DONE still pulses for the granted requester.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM encodings and constants for the UART transmit arbiter
package uart_tx_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    SEND      = 3'd3,
    COMPLETE  = 3'd4
  } state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from the slot after i_last
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_valid
);
  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_mreq;
  // w_mask keeps only slots above i_last; the shift overflows to zero when i_last is the top slot
  assign w_mask = ~((NUM_REQ'(2) << i_last) - NUM_REQ'(1));
  assign w_mreq = i_req & w_mask;
  assign o_gnt = |w_mreq ? w_mreq & (~w_mreq + NUM_REQ'(1)) : i_req & (~i_req + NUM_REQ'(1));
  assign o_valid = |i_req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with launch, busy tracking and timeout
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]            REQ_PAR_TYP,
  input  logic                          TX_BUSY,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          Data_valid,
  output logic                          PAR_EN,
  output logic                          PAR_TYP,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [NUM_REQ-1:0]            DONE,
  output logic                          ERR
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_last, r_idx, w_idx;
  logic [NUM_REQ-1:0]    w_gnt, r_gnt, r_done;
  logic                  w_valid, r_dv, r_pe, r_pt, r_err;
  logic [DATA_WIDTH-1:0] w_data, r_data;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req  (REQ),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_valid(w_valid)
  );
  always_comb begin
    w_idx = '0;
    w_data = '0;
    for (int k = 0; k < NUM_REQ; k++) if (w_gnt[k]) begin
      w_idx = IW'(k);
      w_data = REQ_DATA[DATA_WIDTH*k +: DATA_WIDTH];
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_idx   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_data  <= '0;
      r_dv    <= 1'b0;
      r_pe    <= 1'b0;
      r_pt    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_valid && !TX_BUSY) begin
          r_gnt   <= w_gnt;
          r_idx   <= w_idx;
          r_data  <= w_data;
          r_pe    <= |(REQ_PAR_EN & w_gnt);
          r_pt    <= |(REQ_PAR_TYP & w_gnt);
          r_dv    <= 1'b1;
          r_state <= START;
        end
        START: begin
          r_dv    <= 1'b0;
          r_cnt   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (TX_BUSY) r_state <= SEND;
        else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          r_done  <= r_gnt;
          r_err   <= 1'b1;
          r_state <= COMPLETE;
        end else r_cnt <= r_cnt + CW'(1);
        SEND: if (!TX_BUSY) begin
          r_done  <= r_gnt;
          r_state <= COMPLETE;
        end
        COMPLETE: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_err   <= 1'b0;
          r_last  <= r_idx;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign P_DATA = r_data;
  assign Data_valid = r_dv;
  assign PAR_EN = r_pe;
  assign PAR_TYP = r_pt;
  assign GNT = r_gnt;
  assign DONE = r_done;
  assign ERR = r_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, launch, busy tracking, timeout and reset
module tb_uart_tx_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  REQ = 4'b0000;
  logic [31:0] REQ_DATA = 32'h443322A5;
  logic [3:0]  REQ_PAR_EN = 4'b1011;
  logic [3:0]  REQ_PAR_TYP = 4'b0110;
  logic        TX_BUSY = 1'b0;
  logic [7:0]  P_DATA;
  logic        Data_valid, PAR_EN, PAR_TYP, ERR;
  logic [3:0]  GNT, DONE;
  int checks = 0;
  int errors = 0;
  logic [7:0] byte_tab [4] = '{8'hA5, 8'h22, 8'h33, 8'h44};
  logic [3:0] pe_tab = 4'b1011;
  logic [3:0] pt_tab = 4'b0110;

  uart_tx_arbiter dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA),
    .REQ_PAR_EN(REQ_PAR_EN), .REQ_PAR_TYP(REQ_PAR_TYP), .TX_BUSY(TX_BUSY),
    .P_DATA(P_DATA), .Data_valid(Data_valid), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .GNT(GNT), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge CLK);
  endtask

  task automatic run_frame(input string tag, input int nbusy, input logic [3:0] g,
                           input logic [7:0] d, input logic pe, input logic pt, input logic drop);
    step;
    chk({tag, ":dv"}, Data_valid, 1);
    chk({tag, ":gnt"}, GNT, g);
    chk({tag, ":pdata"}, P_DATA, d);
    chk({tag, ":paren"}, PAR_EN, pe);
    chk({tag, ":partyp"}, PAR_TYP, pt);
    chk({tag, ":done_early"}, DONE, 0);
    step;
    chk({tag, ":dv_drop"}, Data_valid, 0);
    chk({tag, ":gnt_wait"}, GNT, g);
    TX_BUSY = 1'b1;
    repeat (nbusy) begin
      step;
      chk({tag, ":busy_done"}, DONE, 0);
      chk({tag, ":busy_dv"}, Data_valid, 0);
      chk({tag, ":busy_gnt"}, GNT, g);
    end
    TX_BUSY = 1'b0;
    step;
    chk({tag, ":done"}, DONE, g);
    chk({tag, ":err"}, ERR, 0);
    chk({tag, ":gnt_cmp"}, GNT, g);
    chk({tag, ":pdata_cmp"}, P_DATA, d);
    if (drop) REQ = REQ & ~g;
    step;
    chk({tag, ":idle_gnt"}, GNT, 0);
    chk({tag, ":idle_done"}, DONE, 0);
  endtask

  initial begin
    step;
    chk("rst_gnt", GNT, 0);
    chk("rst_dv", Data_valid, 0);
    chk("rst_pdata", P_DATA, 0);
    chk("rst_par", {PAR_EN, PAR_TYP}, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    RST = 1'b1;
    REQ = 4'b0001;
    run_frame("single", 11, 4'b0001, 8'hA5, 1'b1, 1'b0, 1'b1);
    RST = 1'b0;
    step;
    RST = 1'b1;
    REQ = 4'b1111;
    for (int k = 0; k < 6; k++)
      run_frame("rr", 2, 4'b0001 << (k % 4), byte_tab[k%4], pe_tab[k%4], pt_tab[k%4], 1'b0);
    REQ = 4'b0010;
    TX_BUSY = 1'b1;
    repeat (3) begin
      step;
      chk("blk_gnt", GNT, 0);
      chk("blk_dv", Data_valid, 0);
    end
    TX_BUSY = 1'b0;
    run_frame("blk_release", 2, 4'b0010, 8'h22, 1'b1, 1'b1, 1'b1);
    REQ = 4'b0100;
    step;
    chk("to_dv", Data_valid, 1);
    chk("to_gnt", GNT, 4'b0100);
    chk("to_pdata", P_DATA, 8'h33);
    step;
    chk("to_dv_drop", Data_valid, 0);
    repeat (15) begin
      step;
      chk("to_wait_done", DONE, 0);
      chk("to_wait_err", ERR, 0);
      chk("to_wait_dv", Data_valid, 0);
    end
    step;
    chk("to_done", DONE, 4'b0100);
    chk("to_err", ERR, 1);
    REQ = 4'b0000;
    step;
    chk("to_err_clr", ERR, 0);
    chk("to_done_clr", DONE, 0);
    chk("to_gnt_clr", GNT, 0);
    REQ = 4'b0001;
    run_frame("after_to", 1, 4'b0001, 8'hA5, 1'b1, 1'b0, 1'b1);
    REQ = 4'b1000;
    step;
    chk("mid_dv", Data_valid, 1);
    chk("mid_gnt", GNT, 4'b1000);
    step;
    TX_BUSY = 1'b1;
    step;
    step;
    RST = 1'b0;
    #1;
    chk("arst_gnt", GNT, 0);
    chk("arst_dv", Data_valid, 0);
    chk("arst_pdata", P_DATA, 0);
    chk("arst_par", {PAR_EN, PAR_TYP}, 0);
    chk("arst_done", DONE, 0);
    chk("arst_err", ERR, 0);
    REQ = 4'b1001;
    TX_BUSY = 1'b0;
    step;
    RST = 1'b1;
    run_frame("post_rst", 2, 4'b0001, 8'hA5, 1'b1, 1'b0, 1'b1);
    step;
    chk("stab_dv", Data_valid, 1);
    chk("stab_gnt", GNT, 4'b1000);
    chk("stab_pdata", P_DATA, 8'h44);
    step;
    TX_BUSY = 1'b1;
    step;
    REQ_DATA = 32'hFFFFFFFF;
    REQ_PAR_EN = 4'b0000;
    REQ_PAR_TYP = 4'b1111;
    REQ = 4'b0000;
    step;
    step;
    chk("stab_hold_pdata", P_DATA, 8'h44);
    chk("stab_hold_par", {PAR_EN, PAR_TYP}, 2'b10);
    chk("stab_hold_gnt", GNT, 4'b1000);
    chk("stab_hold_done", DONE, 0);
    TX_BUSY = 1'b0;
    step;
    chk("stab_done", DONE, 4'b1000);
    chk("stab_err", ERR, 0);
    chk("stab_cmp_pdata", P_DATA, 8'h44);
    step;
    chk("stab_idle_gnt", GNT, 0);
    chk("stab_idle_done", DONE, 0);
    chk("stab_idle_pdata", P_DATA, 8'h44);
    chk("stab_idle_dv", Data_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
